pipelined_cpu_core: RTL and testbench



---
 rtl/pipelined_cpu_core.sv | 157 +++++++++++++++
 tb/tb_pipelined_cpu_core.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_cpu_core.sv
// Three-stage (FD/EM/WB) core for the 10-bit ISA: full forwarding into decode,
// load-use interlock, external freeze, halt drain and a retired-instruction counter.
module pipelined_cpu_core #(
   parameter int unsigned DW  = 10,
   parameter int unsigned PCW = 10,
   parameter int unsigned RCW = 16
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           stall_i,
   output logic [PCW-1:0] imem_addr,
   input  logic [9:0]     imem_data,
   output logic [DW-1:0]  dmem_addr,
   output logic [DW-1:0]  dmem_wdata,
   output logic           dmem_we,
   input  logic [DW-1:0]  dmem_rdata,
   output logic           halted,
   output logic [RCW-1:0] retire_count
);

   localparam logic [2:0] OpAlu   = 3'b000;
   localparam logic [2:0] OpMisc  = 3'b001;
   localparam logic [2:0] OpBne   = 3'b010;
   localparam logic [2:0] OpAddi  = 3'b011;
   localparam logic [2:0] OpJump  = 3'b100;
   localparam logic [2:0] OpBeq   = 3'b101;
   localparam logic [2:0] OpLoad  = 3'b110;
   localparam logic [2:0] OpStore = 3'b111;

   logic [PCW-1:0] pc_q;
   logic [DW-1:0]  rf_q [8];
   logic           halted_q;
   logic [RCW-1:0] retire_q;

   logic           em_valid_q;
   logic [2:0]     em_op_q;
   logic [1:0]     em_f_q;
   logic [2:0]     em_dst_q;
   logic [DW-1:0]  em_a_q, em_b_q;

   logic           wb_valid_q, wb_we_q;
   logic [2:0]     wb_dst_q;
   logic [DW-1:0]  wb_data_q;

   logic [2:0]     fd_op, fd_ra, fd_rb;
   logic [1:0]     fd_f;
   logic           fd_use_a, fd_use_b;

   assign fd_op    = imem_data[9:7];
   assign fd_ra    = {imem_data[2], imem_data[6:5]};
   assign fd_rb    = {imem_data[2], imem_data[4:3]};
   assign fd_f     = imem_data[1:0];
   assign fd_use_a = !(fd_op == OpJump || (fd_op == OpMisc && fd_f[1]));
   assign fd_use_b = fd_op inside {OpAlu, OpBne, OpBeq, OpStore};

   logic          em_load, em_halt, em_writes, em_fwd;
   logic [DW-1:0] em_alu, em_addr;

   assign em_load   = em_valid_q && em_op_q == OpLoad;
   assign em_halt   = em_valid_q && em_op_q == OpMisc && em_f_q == 2'b10;
   assign em_writes = em_valid_q && (em_op_q inside {OpAlu, OpAddi, OpLoad} ||
                                     (em_op_q == OpMisc && !em_f_q[1]));
   // A load's ALU output is its address, never forwardable data.
   assign em_fwd    = em_writes && !em_load;
   assign em_addr   = em_a_q + DW'(em_f_q);

   always_comb begin
      em_alu = '0;
      case (em_op_q)
         OpAlu: begin
            case (em_f_q)
               2'b00:   em_alu = em_a_q + em_b_q;
               2'b01:   em_alu = em_a_q - em_b_q;
               2'b10:   em_alu = DW'($signed(em_a_q) < $signed(em_b_q));
               default: em_alu = ~(em_a_q & em_b_q);
            endcase
         end
         OpMisc:  em_alu = em_f_q[0] ? {em_a_q[DW-2:0], 1'b0} : {1'b0, em_a_q[DW-1:1]};
         OpAddi:  em_alu = em_a_q + {{(DW-2){em_f_q[1]}}, em_f_q};
         default: em_alu = '0;
      endcase
   end

   logic [DW-1:0] fd_a, fd_b;

   always_comb begin
      fd_a = rf_q[fd_ra];
      fd_b = rf_q[fd_rb];
      if (wb_valid_q && wb_we_q && wb_dst_q == fd_ra) fd_a = wb_data_q;
      if (wb_valid_q && wb_we_q && wb_dst_q == fd_rb) fd_b = wb_data_q;
      if (em_fwd && em_dst_q == fd_ra) fd_a = em_alu;
      if (em_fwd && em_dst_q == fd_rb) fd_b = em_alu;
   end

   logic           load_use, taken, advance;
   logic [PCW-1:0] pc_next;

   assign load_use = em_load && ((fd_use_a && em_dst_q == fd_ra) ||
                                 (fd_use_b && em_dst_q == fd_rb));
   assign taken    = (fd_op == OpBne && fd_a != fd_b) || (fd_op == OpBeq && fd_a == fd_b);
   assign advance  = !stall_i && !halted_q;

   always_comb begin
      pc_next = pc_q + PCW'(1);
      if (fd_op == OpJump)  pc_next = pc_q + PCW'($signed(imem_data[6:0]));
      else if (taken)       pc_next = pc_q + PCW'(1) + PCW'(fd_f);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q       <= '0;
         halted_q   <= 1'b0;
         retire_q   <= '0;
         em_valid_q <= 1'b0;
         em_op_q    <= '0;
         em_f_q     <= '0;
         em_dst_q   <= '0;
         em_a_q     <= '0;
         em_b_q     <= '0;
         wb_valid_q <= 1'b0;
         wb_we_q    <= 1'b0;
         wb_dst_q   <= '0;
         wb_data_q  <= '0;
         for (int i = 0; i < 8; i++) rf_q[i] <= '0;
      end else if (advance) begin
         em_op_q  <= fd_op;
         em_f_q   <= fd_f;
         em_dst_q <= fd_rb;
         em_a_q   <= fd_a;
         em_b_q   <= fd_b;
         // HALT in EM squashes FD and freezes PC; interlock inserts a bubble.
         if (em_halt) begin
            halted_q   <= 1'b1;
            em_valid_q <= 1'b0;
         end else if (load_use) begin
            em_valid_q <= 1'b0;
         end else begin
            pc_q       <= pc_next;
            em_valid_q <= 1'b1;
         end
         wb_valid_q <= em_valid_q && !em_halt;
         wb_we_q    <= em_writes;
         wb_dst_q   <= em_dst_q;
         wb_data_q  <= em_load ? dmem_rdata : em_alu;
         if (wb_valid_q) retire_q <= retire_q + RCW'(1);
         if (wb_valid_q && wb_we_q) rf_q[wb_dst_q] <= wb_data_q;
      end
   end

   assign imem_addr    = pc_q;
   assign dmem_addr    = em_addr;
   assign dmem_we      = em_valid_q && em_op_q == OpStore && !stall_i && !halted_q;
   assign dmem_wdata   = dmem_we ? em_b_q : '0;
   assign halted       = halted_q;
   assign retire_count = retire_q;

endmodule

// File: tb/tb_pipelined_cpu_core.sv
// Scoreboard bench: an ISA-level interpreter predicts stores, retire count and
// cycle count; a monitor compares every DUT store strobe against the queue.
module tb_pipelined_cpu_core;
   localparam int DW   = 10;
   localparam int PCW  = 10;
   localparam int RCW  = 16;
   localparam int MASK = (1 << DW) - 1;
   localparam logic [9:0] HaltW = 10'b001_00_00_0_10;
   localparam logic [9:0] NopW  = 10'b001_00_00_0_11;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           stall_i = 1'b0;
   logic [PCW-1:0] imem_addr;
   logic [9:0]     imem_data;
   logic [DW-1:0]  dmem_addr, dmem_wdata, dmem_rdata;
   logic           dmem_we, halted;
   logic [RCW-1:0] retire_count;

   logic [9:0]    rom  [1 << PCW];
   logic [DW-1:0] dmem [1 << DW];

   int checks = 0;
   int errors = 0;
   bit sb_on = 1'b0;
   logic [2*DW-1:0] exp_q [$];
   int m_retire, m_exec, m_haz;

   pipelined_cpu_core #(.DW(DW), .PCW(PCW), .RCW(RCW)) dut (
      .clk          (clk),
      .rst          (rst),
      .stall_i      (stall_i),
      .imem_addr    (imem_addr),
      .imem_data    (imem_data),
      .dmem_addr    (dmem_addr),
      .dmem_wdata   (dmem_wdata),
      .dmem_we      (dmem_we),
      .dmem_rdata   (dmem_rdata),
      .halted       (halted),
      .retire_count (retire_count)
   );

   always #5 clk = ~clk;

   assign imem_data  = rom[imem_addr];
   assign dmem_rdata = dmem[dmem_addr];

   // Loads and stores never share an edge, so a blocking write is race-free here.
   always @(posedge clk) if (dmem_we) dmem[dmem_addr] = dmem_wdata;

   task automatic check(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   initial begin
      logic [2*DW-1:0] e;
      forever begin
         @(negedge clk);
         if (sb_on && dmem_we) begin
            if (exp_q.size() == 0) check("store_unexpected", {dmem_addr, dmem_wdata}, -1);
            else begin
               e = exp_q.pop_front();
               check("store {addr,data}", {dmem_addr, dmem_wdata}, e);
            end
         end
      end
   end

   function automatic logic [9:0] ins(input int op, input int rs, input int rt, input int b,
                                      input int f);
      return {op[2:0], rs[1:0], rt[1:0], b[0], f[1:0]};
   endfunction

   task automatic clear_rom();
      for (int i = 0; i < (1 << PCW); i++) rom[i] = HaltW;
   endtask

   task automatic dump_at(input int base);
      for (int k = 0; k < 8; k++) rom[base + k] = ins(7, 0, k & 3, k >> 2, k & 3);
   endtask

   task automatic rand_dmem();
      for (int i = 0; i < (1 << DW); i++) dmem[i] = DW'($urandom_range(MASK));
   endtask

   // Forward-only control flow, so every program reaches the dump and HALT.
   task automatic gen_random(input int len);
      logic [9:0] w;
      clear_rom();
      for (int i = 0; i < len; i++) begin
         int op = int'($urandom_range(7));
         int f  = int'($urandom_range(3));
         w = ins(op, int'($urandom_range(3)), int'($urandom_range(3)),
                 int'($urandom_range(1)), f);
         if (op == 4) begin
            int off = int'($urandom_range(4, 1));
            w = (i + off > len) ? NopW : {3'b100, 7'(off)};
         end
         if ((op == 2 || op == 5) && i + 1 + f > len) w = NopW;
         if (op == 1 && f == 2 && $urandom_range(3) != 0) w = NopW;
         rom[i] = w;
      end
      dump_at(len);
   endtask

   // Sequential ISA interpreter; also counts load-use pairs in execution order.
   task automatic model_run();
      int r [8];
      int mm [1 << DW];
      int pc, npc, a, b, ra, rb, op, f, off, addr, last_dst, sa, sb;
      bit ua, ub, last_load, tk;
      logic [9:0] w;
      for (int i = 0; i < 8; i++) r[i] = 0;
      for (int i = 0; i < (1 << DW); i++) mm[i] = int'(dmem[i]);
      pc = 0; last_load = 0; last_dst = 0;
      m_retire = 0; m_exec = 0; m_haz = 0;
      for (int steps = 0; steps < 4000; steps++) begin
         w  = rom[pc];
         op = int'(w[9:7]);
         f  = int'(w[1:0]);
         ra = int'({w[2], w[6:5]});
         rb = int'({w[2], w[4:3]});
         a  = r[ra];
         b  = r[rb];
         ua = !(op == 4 || (op == 1 && f >= 2));
         ub = (op == 0 || op == 2 || op == 5 || op == 7);
         if (last_load && ((ua && ra == last_dst) || (ub && rb == last_dst))) m_haz++;
         m_exec++;
         if (op == 1 && f == 2) break;
         m_retire++;
         npc = pc + 1;
         case (op)
            0: begin
               sa = (a >= (1 << (DW - 1))) ? a - (1 << DW) : a;
               sb = (b >= (1 << (DW - 1))) ? b - (1 << DW) : b;
               if (f == 0) r[rb] = (a + b) & MASK;
               else if (f == 1) r[rb] = (a - b) & MASK;
               else if (f == 2) r[rb] = (sa < sb) ? 1 : 0;
               else r[rb] = (~(a & b)) & MASK;
            end
            1: begin
               if (f == 0) r[rb] = a >> 1;
               else if (f == 1) r[rb] = (a << 1) & MASK;
            end
            2, 5: begin
               tk = (op == 2) ? (a != b) : (a == b);
               if (tk) npc = pc + 1 + f;
            end
            3: r[rb] = (a + ((f >= 2) ? f - 4 : f)) & MASK;
            4: begin
               off = int'(w[6:0]);
               if (off >= 64) off = off - 128;
               npc = pc + off;
            end
            6: r[rb] = mm[(a + f) & MASK];
            default: begin
               addr = (a + f) & MASK;
               exp_q.push_back({addr[DW-1:0], b[DW-1:0]});
               mm[addr] = b;
            end
         endcase
         last_load = (op == 6);
         last_dst  = rb;
         pc = npc & ((1 << PCW) - 1);
      end
   endtask

   task automatic start_prog(input bit sb);
      rst = 1'b1; stall_i = 1'b0; sb_on = 1'b0;
      @(negedge clk);
      exp_q.delete();
      model_run();
      sb_on = sb;
      #2 rst = 1'b0;
   endtask

   // Counts edges with stall_i low until halted; bounded.
   task automatic drive_to_halt(input bit rnd_stall, output int active);
      int cyc = 0;
      active = 0;
      while (!halted && cyc < 3000) begin
         stall_i = rnd_stall && ($urandom_range(3) == 0);
         @(posedge clk);
         if (!stall_i) active++;
         #1 cyc++;
      end
      stall_i = 1'b0;
   endtask

   task automatic end_checks(input string name, input int active);
      check({name, "/halted"}, halted, 1);
      check({name, "/active_cycles"}, active, m_exec + 1 + m_haz);
      repeat (3) @(negedge clk);
      check({name, "/halted_sticky"}, halted, 1);
      check({name, "/retire_count"}, retire_count, m_retire % (1 << RCW));
      check({name, "/stores_left"}, exp_q.size(), 0);
   endtask

   task automatic run_prog(input string name, input bit rnd_stall);
      int active;
      start_prog(1'b1);
      drive_to_halt(rnd_stall, active);
      end_checks(name, active);
   endtask

   initial begin
      int active;
      clear_rom();
      rand_dmem();
      #1 rst = 1'b1;
      #1;
      check("reset/imem_addr", imem_addr, 0);
      check("reset/halted", halted, 0);
      check("reset/retire_count", retire_count, 0);
      check("reset/dmem_we", dmem_we, 0);
      check("reset/dmem_wdata", dmem_wdata, 0);

      // Forwarding chain, then store r1.
      clear_rom();
      rom[0] = ins(3, 0, 1, 0, 1);
      rom[1] = ins(0, 1, 1, 0, 0);
      rom[2] = ins(0, 1, 1, 0, 0);
      rom[3] = ins(7, 0, 1, 0, 0);
      run_prog("fwd_chain", 1'b0);

      // Load-use with one bubble.
      clear_rom();
      dmem[2] = 10'h155;
      rom[0] = ins(6, 0, 2, 0, 2);
      rom[1] = ins(0, 2, 2, 0, 0);
      rom[2] = ins(7, 0, 2, 0, 1);
      run_prog("load_use", 1'b0);

      // Forwarded BEQ skipping two instructions.
      clear_rom();
      rom[0] = ins(3, 0, 1, 0, 1);
      rom[1] = ins(5, 1, 1, 0, 2);
      rom[2] = ins(3, 0, 2, 0, 1);
      rom[3] = ins(3, 0, 3, 0, 1);
      dump_at(4);
      run_prog("branch", 1'b0);

      // Halt drain.
      clear_rom();
      rom[0] = ins(3, 0, 1, 0, 3);
      rom[1] = HaltW;
      rom[2] = ins(3, 0, 2, 0, 1);
      run_prog("halt_drain", 1'b0);

      // Freeze with a STORE in EM for three edges.
      clear_rom();
      rom[0] = ins(3, 0, 1, 0, 3);
      rom[1] = ins(7, 0, 1, 0, 3);
      start_prog(1'b1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      stall_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("freeze/dmem_we", dmem_we, 0);
         check("freeze/imem_addr", imem_addr, 2);
         @(posedge clk); #1;
      end
      stall_i = 1'b0;
      drive_to_halt(1'b0, active);
      end_checks("freeze", active + 2);

      // Asynchronous reset mid-run, then dump registers without a synchronous reset.
      gen_random(20);
      rand_dmem();
      start_prog(1'b0);
      repeat (12) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("midreset/imem_addr", imem_addr, 0);
      check("midreset/halted", halted, 0);
      check("midreset/retire_count", retire_count, 0);
      check("midreset/dmem_we", dmem_we, 0);
      clear_rom();
      dump_at(0);
      exp_q.delete();
      model_run();
      sb_on = 1'b1;
      #1 rst = 1'b0;
      drive_to_halt(1'b0, active);
      end_checks("midreset_regs", active);

      for (int n = 0; n < 10; n++) begin
         gen_random(16 + n);
         rand_dmem();
         run_prog($sformatf("rand%0d", n), n[0]);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
